// File: rtl/cam_pkg.sv
// Shared constants for the tag CAM and its write-side allocator, plus small
// popcount helpers used by the allocator.
package cam_pkg;

  localparam int CAM_DEPTH    = 16;
  localparam int CAM_INDEX    = 4;
  localparam int CAM_WIDTH    = 8;
  localparam int NUM_WR_PORTS = 4;
  localparam int NUM_RD_PORTS = 6;

  // Number of set bits in a 4-bit request/grant vector.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  // Number of set bits in an entry-wide mask.
  function automatic logic [CAM_INDEX:0] popcount_depth(input logic [CAM_DEPTH-1:0] v);
    logic [CAM_INDEX:0] c;
    c = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      c = c + {{CAM_INDEX{1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/cam_free_pick.sv
// Combinational finder for the four lowest-indexed set bits of a free mask.
// idxN_o is the index of the N-th lowest set bit; vld_o[N] says it exists.
module cam_free_pick
  import cam_pkg::*;
(
  input  logic [CAM_DEPTH-1:0]    free_mask,
  output logic [CAM_INDEX-1:0]    idx0_o,
  output logic [CAM_INDEX-1:0]    idx1_o,
  output logic [CAM_INDEX-1:0]    idx2_o,
  output logic [CAM_INDEX-1:0]    idx3_o,
  output logic [NUM_WR_PORTS-1:0] vld_o
);

  logic [CAM_INDEX-1:0] idx_arr [NUM_WR_PORTS];
  logic [2:0]           cnt;

  // Scan entries upward, recording the first four free ones in order.
  always_comb begin
    cnt   = '0;
    vld_o = '0;
    for (int n = 0; n < NUM_WR_PORTS; n++) begin
      idx_arr[n] = '0;
    end
    for (int i = 0; i < CAM_DEPTH; i++) begin
      if (free_mask[i] && !cnt[2]) begin
        idx_arr[cnt[1:0]] = CAM_INDEX'(i);
        vld_o[cnt[1:0]]   = 1'b1;
        cnt               = cnt + 3'd1;
      end
    end
  end

  assign idx0_o = idx_arr[0];
  assign idx1_o = idx_arr[1];
  assign idx2_o = idx_arr[2];
  assign idx3_o = idx_arr[3];

endmodule

// File: rtl/cam_entry_alloc.sv
// Write-side allocator for the tag CAM. Tracks used entries, grants up to four
// requests per cycle (all-or-nothing) to the lowest free entries, and registers
// the CAM write ports one cycle after the grant.
//
// Handshake: req_i[N] is a request held by the producer; grant_o[N] is the
// same-cycle acceptance. A request is consumed only in a cycle where grant_o[N]
// is high; when stall_o is high nothing is consumed and the producer must hold
// or re-present its requests. No request is ever partially granted.
//
// Optional feature macro: CAM_ALLOC_STATS_EN adds stall_cnt_o and hiwater_o.
module cam_entry_alloc
  import cam_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req_i,
  input  logic [CAM_WIDTH-1:0] tag0req_i,
  input  logic [CAM_WIDTH-1:0] tag1req_i,
  input  logic [CAM_WIDTH-1:0] tag2req_i,
  input  logic [CAM_WIDTH-1:0] tag3req_i,
  input  logic [CAM_DEPTH-1:0] free_vec_i,
  output logic [3:0]           grant_o,
  output logic                 stall_o,
  output logic [CAM_INDEX-1:0] addr0_o,
  output logic [CAM_INDEX-1:0] addr1_o,
  output logic [CAM_INDEX-1:0] addr2_o,
  output logic [CAM_INDEX-1:0] addr3_o,
  output logic                 we0_o,
  output logic                 we1_o,
  output logic                 we2_o,
  output logic                 we3_o,
  output logic [CAM_INDEX-1:0] addr0wr_o,
  output logic [CAM_INDEX-1:0] addr1wr_o,
  output logic [CAM_INDEX-1:0] addr2wr_o,
  output logic [CAM_INDEX-1:0] addr3wr_o,
  output logic [CAM_WIDTH-1:0] tag0wr_o,
  output logic [CAM_WIDTH-1:0] tag1wr_o,
  output logic [CAM_WIDTH-1:0] tag2wr_o,
  output logic [CAM_WIDTH-1:0] tag3wr_o,
  output logic [CAM_INDEX:0]   free_cnt_o
`ifdef CAM_ALLOC_STATS_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [CAM_INDEX:0]   hiwater_o
`endif
);

  logic [CAM_DEPTH-1:0]    used_q;
  logic [CAM_DEPTH-1:0]    used_nxt;
  logic [CAM_DEPTH-1:0]    free_hit;
  logic [CAM_DEPTH-1:0]    alloc_mask;
  logic [CAM_INDEX:0]      free_cnt_q;
  logic [CAM_INDEX:0]      free_cnt_nxt;

  logic [2:0]              req_cnt;
  logic                    grant_ok;
  logic [NUM_WR_PORTS-1:0] grant;
  logic                    stall;
  logic [NUM_WR_PORTS-1:0] slot_ok;
  logic [1:0]              rank;

  logic [CAM_WIDTH-1:0]    tag_req   [NUM_WR_PORTS];
  logic [CAM_INDEX-1:0]    pick_idx  [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0] pick_vld;
  logic [CAM_INDEX-1:0]    addr_sel  [NUM_WR_PORTS];

  logic [NUM_WR_PORTS-1:0] we_q;
  logic [CAM_INDEX-1:0]    addr_wr_q [NUM_WR_PORTS];
  logic [CAM_WIDTH-1:0]    tag_wr_q  [NUM_WR_PORTS];

  assign tag_req[0] = tag0req_i;
  assign tag_req[1] = tag1req_i;
  assign tag_req[2] = tag2req_i;
  assign tag_req[3] = tag3req_i;

  // Free list comes from registered state only: same-cycle frees are invisible.
  cam_free_pick u_pick (
    .free_mask (~used_q),
    .idx0_o    (pick_idx[0]),
    .idx1_o    (pick_idx[1]),
    .idx2_o    (pick_idx[2]),
    .idx3_o    (pick_idx[3]),
    .vld_o     (pick_vld)
  );

  // All-or-nothing grant: accept every request or none of them.
  always_comb begin
    req_cnt  = popcount4(req_i);
    grant_ok = ({2'b00, req_cnt} <= free_cnt_q);
    grant    = grant_ok ? req_i : '0;
    // Refusal implies req_cnt > free_cnt >= 0, so a request is pending.
    stall    = !grant_ok;
  end

  // The j-th requesting slot (ascending) takes the j-th lowest free entry.
  always_comb begin
    rank       = '0;
    slot_ok    = '0;
    alloc_mask = '0;
    for (int n = 0; n < NUM_WR_PORTS; n++) begin
      addr_sel[n] = pick_idx[rank];
      slot_ok[n]  = grant[n] & pick_vld[rank];
      if (slot_ok[n]) begin
        alloc_mask[addr_sel[n]] = 1'b1;
      end
      if (req_i[n]) begin
        rank = rank + 2'd1;
      end
    end
  end

  // Next bitmap and free count; frees only count against entries in use.
  always_comb begin
    free_hit     = free_vec_i & used_q;
    used_nxt     = (used_q & ~free_hit) | alloc_mask;
    free_cnt_nxt = free_cnt_q - {2'b00, popcount4(slot_ok)} + popcount_depth(free_hit);
  end

  // Bitmap and free-count state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      used_q     <= '0;
      free_cnt_q <= (CAM_INDEX+1)'(CAM_DEPTH);
    end else begin
      used_q     <= used_nxt;
      free_cnt_q <= free_cnt_nxt;
    end
  end

  // CAM write ports: one-cycle enable pulse; address/tag hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q <= '0;
      for (int n = 0; n < NUM_WR_PORTS; n++) begin
        addr_wr_q[n] <= '0;
        tag_wr_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_WR_PORTS; n++) begin
        we_q[n] <= slot_ok[n];
        if (slot_ok[n]) begin
          addr_wr_q[n] <= addr_sel[n];
          tag_wr_q[n]  <= tag_req[n];
        end
      end
    end
  end

`ifdef CAM_ALLOC_STATS_EN
  logic [31:0]        stall_cnt_q;
  logic [CAM_INDEX:0] hiwater_q;
  logic [CAM_INDEX:0] used_cnt_nxt;

  // Occupancy after this edge, used for the high-water mark.
  always_comb begin
    used_cnt_nxt = (CAM_INDEX+1)'(CAM_DEPTH) - free_cnt_nxt;
  end

  // Saturating stall counter and occupancy high-water mark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      hiwater_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (used_cnt_nxt > hiwater_q) begin
        hiwater_q <= used_cnt_nxt;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign hiwater_o   = hiwater_q;
`endif

  assign grant_o    = grant;
  assign stall_o    = stall;
  assign addr0_o    = addr_sel[0];
  assign addr1_o    = addr_sel[1];
  assign addr2_o    = addr_sel[2];
  assign addr3_o    = addr_sel[3];
  assign we0_o      = we_q[0];
  assign we1_o      = we_q[1];
  assign we2_o      = we_q[2];
  assign we3_o      = we_q[3];
  assign addr0wr_o  = addr_wr_q[0];
  assign addr1wr_o  = addr_wr_q[1];
  assign addr2wr_o  = addr_wr_q[2];
  assign addr3wr_o  = addr_wr_q[3];
  assign tag0wr_o   = tag_wr_q[0];
  assign tag1wr_o   = tag_wr_q[1];
  assign tag2wr_o   = tag_wr_q[2];
  assign tag3wr_o   = tag_wr_q[3];
  assign free_cnt_o = free_cnt_q;

endmodule
